// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// FSM state encoding, RISC-V branch opcode, canonical NOP and a helper that
// assembles and sign-extends the B-type immediate.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // B-immediate: 12 encoded bits plus an implicit zero LSB
  localparam int BIMM_FIELD_W = 12;
  localparam int BIMM_W       = BIMM_FIELD_W + 1;

  // fields = {instr[31], instr[7], instr[30:25], instr[11:8]}
  function automatic logic [31:0] bimm_sext(input logic [BIMM_FIELD_W-1:0] fields);
    logic [BIMM_W-1:0] imm;
    imm = {fields, 1'b0};
    return {{(32-BIMM_W){imm[BIMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/bimm_predict.sv
// bimm_predict: static backward-taken predictor for conditional branches.
// Purely combinational; only instantiated when FETCH_BRANCH_PREDICT_EN is set.
module bimm_predict
  import fetch_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic [BIMM_FIELD_W-1:0] imm_fields;
  logic                    unused_bits;

  assign imm_fields = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};

  // A conditional branch with a negative offset (sign bit set) is assumed to close a loop
  assign pred_taken  = (instruction[6:0] == OPC_BRANCH) && instruction[31];
  assign pred_target = pc + bimm_sext(imm_fields);

  // register and funct3 fields play no part in the prediction
  assign unused_bits = ^instruction[24:12];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and single-outstanding instruction fetcher.
// Issues one word read at a time, presents the fetched word to decode over
// valid/ready, and restarts at redirect_pc, discarding any stale response.
// Optional feature macro: FETCH_BRANCH_PREDICT_EN (static backward-taken
// branch prediction through bimm_predict); undefined means pc+4 always.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        pred_taken,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         pred_q, pred_d;

  logic [31:0]  seq_pc;
  logic [31:0]  redir_pc;
  logic         cap_pred;
  logic [31:0]  cap_next_pc;

  assign seq_pc   = pc_q + 32'd4;
  assign redir_pc = redirect_pc & ~32'd3;

`ifdef FETCH_BRANCH_PREDICT_EN
  logic        bp_taken;
  logic [31:0] bp_target;

  bimm_predict u_bimm_predict (
    .instruction (imem_rdata),
    .pc          (pc_q),
    .pred_taken  (bp_taken),
    .pred_target (bp_target)
  );

  assign cap_pred    = bp_taken;
  assign cap_next_pc = bp_taken ? bp_target : seq_pc;
`else
  assign cap_pred    = 1'b0;
  assign cap_next_pc = seq_pc;
`endif

  // Next-state and next-output logic; redirect overrides everything else
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pred_d  = pred_q;

    unique case (state_q)
      ISSUE: begin
        // req_q low here only in the first cycle after reset: nothing went out yet
        if (redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = req_q ? DRAIN : ISSUE;
        end else if (req_q) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          // a response arriving alongside the redirect is dropped on the spot
          state_d = imem_rvalid ? ISSUE : DRAIN;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pred_d  = cap_pred;
          valid_d = 1'b1;
          pc_d    = cap_next_pc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = ISSUE;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
        end
        if (imem_rvalid) begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase

    // the request strobe is registered from the state being entered
    if (state_d == ISSUE) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pred_q  <= pred_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign inst_pc     = ipc_q;
  assign pred_taken  = pred_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a random-latency
// memory model, directed scenarios and a randomized redirect/backpressure run.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        pred_taken;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .pred_taken  (pred_taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0000_0120) return 32'hFE00_0EE3;
    h = (a * 32'h9E37_79B1) ^ (a >> 7) ^ 32'h5A5A_1234;
    if (a[4:2] == 3'd5) h[6:0] = 7'b1100011;
    return h;
  endfunction

  function automatic logic ref_pred(input logic [31:0] w);
`ifdef FETCH_BRANCH_PREDICT_EN
    return (w[6:0] == 7'b1100011) && w[31];
`else
    return w[0] & 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [31:0] w);
    if (ref_pred(w)) return a + {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    return a + 32'd4;
  endfunction

  // ---------------- memory model ----------------
  int          lat_mode = 1;   // 0: random 1..4, otherwise fixed latency
  int          mem_cnt = 0;
  logic [31:0] mem_a = 32'd0;

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (reset) begin
      mem_cnt = 0;
    end else begin
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_a);
        end
      end
      if (imem_req) begin
        mem_cnt = (lat_mode == 0) ? int'($urandom_range(4, 1)) : lat_mode;
        mem_a   = imem_addr;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pred;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] model_pc = 32'h100;
  bit          outstanding = 0, stale = 0, req_due = 0, valid_due = 0;
  bit          p_valid = 0, p_ready = 0, p_redirect = 0, p_pred = 0;
  logic [31:0] p_ins = 0, p_pc = 0;
  int          hs_cnt = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] w;
    if (reset) begin
      chk(imem_req == 1'b0, "rst_imem_req", imem_req, 0);
      chk(imem_addr == 32'd0, "rst_imem_addr", imem_addr, 0);
      chk(inst_valid == 1'b0, "rst_inst_valid", inst_valid, 0);
      chk(instruction == 32'd0, "rst_instruction", instruction, 0);
      chk(inst_pc == 32'd0, "rst_inst_pc", inst_pc, 0);
      chk(pred_taken == 1'b0, "rst_pred_taken", pred_taken, 0);
      model_pc = 32'h100;
      exp_q.delete();
      outstanding = 0; stale = 0; req_due = 0; valid_due = 0; p_valid = 0;
    end else begin
      // obligations carried over from the previous cycle
      if (p_valid && !p_ready && !p_redirect) begin
        chk(inst_valid == 1'b1, "hold_valid", inst_valid, 1);
        chk(instruction == p_ins, "hold_instr", instruction, p_ins);
        chk(inst_pc == p_pc, "hold_pc", inst_pc, p_pc);
        chk(pred_taken == p_pred, "hold_pred", pred_taken, p_pred);
      end else if (p_valid) begin
        chk(inst_valid == 1'b0, "valid_drop", inst_valid, 0);
      end else if (!valid_due) begin
        chk(inst_valid == 1'b0, "spurious_valid", inst_valid, 0);
      end
      if (valid_due) chk(inst_valid == 1'b1, "valid_timing", inst_valid, 1);
      if (req_due) chk(imem_req == 1'b1, "req_timing", imem_req, 1);
      req_due = 0;
      valid_due = 0;

      if (imem_req) begin
        chk(!outstanding, "one_outstanding", outstanding, 0);
        chk(!inst_valid, "req_while_valid", inst_valid, 0);
        chk(imem_addr == model_pc, "req_addr", imem_addr, model_pc);
        req_log.push_back(imem_addr);
        w = mem_word(model_pc);
        e.pc = model_pc; e.ins = w; e.pred = ref_pred(w);
        exp_q.push_back(e);
        model_pc = ref_next(model_pc, w);
        outstanding = 1;
        stale = 0;
      end

      if (imem_rvalid) begin
        outstanding = 0;
        if (stale || redirect) req_due = 1;
        else valid_due = 1;
        stale = 0;
      end

      if (inst_valid && inst_ready) begin
        chk(exp_q.size() != 0, "sb_unexpected_inst", inst_pc, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(inst_pc == e.pc, "sb_inst_pc", inst_pc, e.pc);
          chk(instruction == e.ins, "sb_instruction", instruction, e.ins);
          chk(pred_taken == e.pred, "sb_pred_taken", pred_taken, e.pred);
        end
        acc_log.push_back(inst_pc);
        hs_cnt++;
        req_due = 1;
      end

      if (redirect) begin
        model_pc = redirect_pc & ~32'd3;
        exp_q.delete();
        if (outstanding) stale = 1;
        else req_due = 1;
      end

      p_valid = inst_valid; p_ready = inst_ready; p_redirect = redirect;
      p_ins = instruction; p_pc = inst_pc; p_pred = pred_taken;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req_count(input int target, input string name);
    for (int i = 0; i < 60 && req_log.size() < target; i++) cyc();
    chk(req_log.size() >= target, name, req_log.size(), target);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 60 && !inst_valid; i++) cyc();
    chk(inst_valid == 1'b1, name, inst_valid, 1);
  endtask

  initial begin
    int n, m, hs0;
    logic [31:0] exp_pred_addr;
    repeat (3) cyc();
    reset = 1'b0;

    // sequential fetch from RESET_PC with latency 1
    for (int i = 0; i < 100 && hs_cnt < 3; i++) cyc();
    chk(hs_cnt >= 3, "seq_progress", hs_cnt, 3);
    if (req_log.size() >= 3) begin
      chk(req_log[0] == 32'h100, "seq_addr0", req_log[0], 32'h100);
      chk(req_log[1] == 32'h104, "seq_addr1", req_log[1], 32'h104);
      chk(req_log[2] == 32'h108, "seq_addr2", req_log[2], 32'h108);
    end

    // backpressure: five cycles of inst_ready=0 while valid
    inst_ready = 1'b0;
    wait_valid("bp_wait_valid");
    repeat (5) cyc();
    chk(inst_valid == 1'b1, "bp_still_valid", inst_valid, 1);
    inst_ready = 1'b1;

    // redirect one cycle after a request, latency 3
    lat_mode = 3;
    for (int i = 0; i < 60; i++) begin cyc(); if (imem_req) break; end
    chk(imem_req == 1'b1, "wait_req_seen", imem_req, 1);
    cyc();
    redirect = 1'b1; redirect_pc = 32'h200;
    n = req_log.size(); m = acc_log.size();
    cyc();
    redirect = 1'b0;
    wait_req_count(n + 1, "redir_wait_req");
    if (req_log.size() > n) chk(req_log[n] == 32'h200, "redir_wait_addr", req_log[n], 32'h200);
    for (int i = 0; i < 60 && acc_log.size() <= m; i++) cyc();
    chk(acc_log.size() > m, "redir_wait_accept", acc_log.size(), m + 1);
    if (acc_log.size() > m) chk(acc_log[m] == 32'h200, "redir_first_pc", acc_log[m], 32'h200);

    // redirect coincident with a response
    lat_mode = 2;
    for (int i = 0; i < 60; i++) begin cyc(); if (imem_rvalid) break; end
    chk(imem_rvalid == 1'b1, "coinc_rvalid_seen", imem_rvalid, 1);
    redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    chk(imem_req == 1'b1, "coinc_next_req", imem_req, 1);
    chk(imem_addr == 32'h300, "coinc_next_addr", imem_addr, 32'h300);

    // wrap and alignment, redirect while holding
    lat_mode = 1;
    inst_ready = 1'b0;
    wait_valid("wrap_wait_valid");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    n = req_log.size();
    cyc();
    redirect = 1'b0; inst_ready = 1'b1;
    wait_req_count(n + 2, "wrap_wait_req");
    if (req_log.size() >= n + 2) begin
      chk(req_log[n] == 32'hFFFF_FFFC, "wrap_addr0", req_log[n], 32'hFFFF_FFFC);
      chk(req_log[n+1] == 32'h0, "wrap_addr1", req_log[n+1], 32'h0);
    end

    // backward branch at 0x120
    inst_ready = 1'b0;
    wait_valid("pred_wait_valid");
    redirect = 1'b1; redirect_pc = 32'h120;
    n = req_log.size();
    cyc();
    redirect = 1'b0; inst_ready = 1'b1;
`ifdef FETCH_BRANCH_PREDICT_EN
    exp_pred_addr = 32'h11C;
`else
    exp_pred_addr = 32'h124;
`endif
    wait_req_count(n + 2, "pred_wait_req");
    if (req_log.size() >= n + 2) begin
      chk(req_log[n] == 32'h120, "pred_branch_addr", req_log[n], 32'h120);
      chk(req_log[n+1] == exp_pred_addr, "pred_next_addr", req_log[n+1], exp_pred_addr);
    end

    // randomized latency, backpressure and redirects
    lat_mode = 0;
    hs0 = hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(9, 0) < 7);
      redirect   = ($urandom_range(99, 0) < 3);
      if (redirect) begin
        case ($urandom_range(3, 0))
          0: redirect_pc = $urandom;
          1: redirect_pc = 32'h100 + $urandom_range(1023, 0);
          2: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15, 0);
          default: redirect_pc = 32'h120;
        endcase
      end
      cyc();
    end
    redirect = 1'b0;
    inst_ready = 1'b1;
    repeat (30) cyc();
    chk((hs_cnt - hs0) >= 200, "random_progress", hs_cnt - hs0, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction fetch stage for the sequential RISC-V core.
- Holds the PC and issues one word read at a time to instruction memory.
- Presents each fetched instruction and its PC to the decode/control block over a valid/ready handshake.
- Accepts PC redirects from branch resolution and discards any stale in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle read request strobe
- imem_addr  out  32  word-aligned read address, valid while imem_req=1
- imem_rvalid  in  1  read data valid; at least 1 cycle after imem_req, one response per request
- imem_rdata  in  32  read data, valid with imem_rvalid
- inst_valid  out  1  instruction/inst_pc/pred_taken valid for decode
- inst_ready  in  1  decode accepts when inst_valid=1 and inst_ready=1
- instruction  out  32  fetched instruction word
- inst_pc  out  32  address of instruction
- pred_taken  out  1  fetch predicted this branch taken (0 when prediction compiled out)
- redirect  in  1  branch resolution: restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] forced to 0

## Operation
- Reset values:
  - pc=RESET_PC, state=ISSUE.
  - imem_req=0, imem_addr=0.
  - inst_valid=0, instruction=0, inst_pc=0, pred_taken=0.
- States and transitions:
  - ISSUE: imem_req=1 and imem_addr=pc for one cycle. Next state is WAIT.
  - WAIT: on imem_rvalid, register instruction=imem_rdata, inst_pc=pc, pred_taken, and inst_valid=1. Set pc=next_pc. Next state is HOLD.
  - HOLD: outputs stable. On handshake, inst_valid=0 and the next state is ISSUE.
  - DRAIN: wait for the stale response, drop it, then go to ISSUE.
- next_pc:
  - Default is pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - The prediction override is described under Configuration.
- Redirect has highest priority in every state:
  - pc=redirect_pc & ~3 and inst_valid=0.
  - From ISSUE or WAIT without imem_rvalid: a response is outstanding, so go to DRAIN.
  - From WAIT with imem_rvalid in the same cycle: drop that response and go to ISSUE.
  - From HOLD: go to ISSUE. If the handshake also occurs that cycle, it counts as accepted.
  - From DRAIN: update pc and stay in DRAIN.
- Only one memory request is ever outstanding.
- No imem_req is issued while inst_valid=1 and the instruction has not been accepted.
- Backpressure: in HOLD with inst_ready=0, all outputs hold indefinitely.

## Timing
- Memory latency L ≥ 1 (imem_rvalid L cycles after imem_req).
- inst_valid rises L+1 cycles after the imem_req cycle.
- Best-case throughput with L=1 and inst_ready=1 is one instruction per 3 cycles (ISSUE, WAIT, HOLD).
- After redirect in HOLD, the next imem_req is on the following cycle.
- After redirect in DRAIN, the first imem_req is the cycle after the stale imem_rvalid.
- All outputs are registered; no combinational path from imem_rdata or inst_ready to outputs.
- Exception: imem_req is decoded from state, so it is registered as well.

## Configuration
- Macro: FETCH_BRANCH_PREDICT_EN.
- Defined (static backward-taken prediction):
  - Applies when a fetched word has opcode 7'b1100011 and instruction[31]=1.
  - next_pc = pc + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), and pred_taken=1.
  - Otherwise pc+4 and pred_taken=0.
- Undefined:
  - next_pc always pc+4 and pred_taken tied to 0.
  - Downstream redirect alone corrects control flow.

## Structure
- fetch_pkg holds:
  - State enum (ISSUE, WAIT, HOLD, DRAIN).
  - OPC_BRANCH=7'b1100011.
  - NOP=32'h0000_0013.
  - Function or localparam widths for the B-immediate.
- Sub-module bimm_predict (combinational): instruction and pc in, pred_taken and pred_target out.
  - Instantiated only under FETCH_BRANCH_PREDICT_EN.

## Test plan
- Reset and sequential fetch:
  - RESET_PC=32'h100, L=1, inst_ready=1.
  - Expect imem_addr 0x100, 0x104, 0x108 on successive requests.
  - Expect inst_pc to match, and the first inst_valid 2 cycles after the first imem_req.
- Backpressure:
  - Hold inst_ready=0 for 5 cycles while inst_valid=1.
  - Expect instruction, inst_pc, and pred_taken stable, and imem_req=0 throughout.
- Redirect in WAIT (L=3):
  - Assert redirect to 0x200 one cycle after imem_req for 0x104.
  - Expect the stale data never presented and the next imem_addr=0x200.
  - Expect the first valid inst_pc after redirect to be 0x200.
- Redirect coincident with imem_rvalid:
  - Expect the data dropped and imem_req for the redirect_pc on the next cycle, with no DRAIN.
- Wrap and alignment:
  - Redirect to 32'hFFFF_FFFE.
  - Expect imem_addr=0xFFFF_FFFC, then 0x0000_0000.
- Prediction with FETCH_BRANCH_PREDICT_EN:
  - Stimulus: at pc 0x120, imem_rdata=32'hFE00_0EE3 (beq x0,x0,-4).
  - Expect pred_taken=1 and next imem_addr=0x11C.
  - Without the macro: pred_taken=0 and next imem_addr=0x124.
